// File: rtl/gs_sin_serializer.sv
// Grayscale shift-interface transmitter: generates SCLK, fetches pixel words and shifts SIN/LAT to the LED drivers.
// Optional build macro GS_TEST_PATTERN_EN adds a test_mode input that replaces RAM data with a fixed pattern.
module gs_sin_serializer #(
  parameter int NB_ANGLES         = 128,
  parameter int NB_LEDS_PER_GROUP = 16,
  parameter int NB_CHAINS         = 8,
  parameter int COLOR_DEPTH       = 10,
  parameter int SCLK_DIV          = 4,
  localparam int ANGLE_WIDTH = $clog2(NB_ANGLES),
  localparam int LED_WIDTH   = $clog2(NB_LEDS_PER_GROUP),
  localparam int ADDR_WIDTH  = ANGLE_WIDTH + 2 + LED_WIDTH + 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [ANGLE_WIDTH-1:0]           angle,
  input  logic [LED_WIDTH-1:0]             led,
  input  logic [1:0]                       color,
  input  logic [3:0]                       bit_sel,
  input  logic [3:0]                       row_en,
  input  logic                             LAT,
`ifdef GS_TEST_PATTERN_EN
  input  logic                             test_mode,
`endif
  output logic                             SCLK,
  output logic [NB_CHAINS-1:0]             SIN,
  output logic                             LAT_out,
  output logic                             rd_en,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [NB_CHAINS*COLOR_DEPTH-1:0] rd_data
);

  localparam int PH_WIDTH = $clog2(SCLK_DIV);
  localparam logic [PH_WIDTH-1:0] PH_ZERO = {PH_WIDTH{1'b0}};
  localparam logic [PH_WIDTH-1:0] PH_ONE  = PH_WIDTH'(1);
  localparam logic [PH_WIDTH-1:0] PH_TWO  = PH_WIDTH'(2);
  localparam logic [PH_WIDTH-1:0] PH_HALF = PH_WIDTH'(SCLK_DIV / 2);
  localparam logic [PH_WIDTH-1:0] PH_LAST = PH_WIDTH'(SCLK_DIV - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [PH_WIDTH-1:0]   phase_q, phase_d;
  logic                  sclk_q, sclk_d;
  logic                  valid_q, valid_d;
  logic [3:0]            bitsel_q, bitsel_d;
  logic                  lat_cap_q, lat_cap_d;
  logic [NB_CHAINS-1:0]  sin_q, sin_d;
  logic                  lat_out_q, lat_out_d;
  logic [1:0]            row_idx_s;
  logic                  ph1_s, ph2_s, read_ok_s, tmode_s;
  logic [NB_CHAINS-1:0]  sin_load_s;
`ifdef GS_TEST_PATTERN_EN
  logic                  tmode_q, tmode_d;
  logic [NB_CHAINS-1:0]  pat_q, pat_d, pat_s;
  assign tmode_s = test_mode;
`else
  assign tmode_s = 1'b0;
`endif

  assign ph1_s     = (state_q == ST_RUN) && (phase_q == PH_ONE);
  assign ph2_s     = (state_q == ST_RUN) && (phase_q == PH_TWO);
  assign read_ok_s = (row_en != 4'b0000) && (color != 2'd3) && !tmode_s;
  // Reads are issued combinationally in phase 1 because the sequencer only updates its indexes at the end of phase 0.
  assign rd_en     = ph1_s && read_ok_s;
  assign rd_addr   = ph1_s ? {angle, row_idx_s, led, color} : {ADDR_WIDTH{1'b0}};
  assign SCLK      = sclk_q;
  assign SIN       = sin_q;
  assign LAT_out   = lat_out_q;

  // One-hot multiplex row to row index
  always_comb begin
    row_idx_s = 2'd0;
    case (row_en)
      4'b0001: row_idx_s = 2'd0;
      4'b0010: row_idx_s = 2'd1;
      4'b0100: row_idx_s = 2'd2;
      4'b1000: row_idx_s = 2'd3;
      default: row_idx_s = 2'd0;
    endcase
  end

  // Per-chain bit plane selected from the returned RAM word
  always_comb begin
    sin_load_s = {NB_CHAINS{1'b0}};
    for (int c = 0; c < NB_CHAINS; c++) begin
      sin_load_s[c] = rd_data[c*COLOR_DEPTH + int'(bitsel_q)];
    end
  end

`ifdef GS_TEST_PATTERN_EN
  // Test pattern: alternating chains on odd LEDs, gated by color matching the row
  always_comb begin
    pat_s = {NB_CHAINS{1'b0}};
    for (int c = 0; c < NB_CHAINS; c++) begin
      pat_s[c] = (led[0] ^ c[0]) & (color == row_idx_s);
    end
  end
`endif

  // Run/idle control, phase counter, phase-1 capture and phase-2 shift load
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    valid_d   = valid_q;
    bitsel_d  = bitsel_q;
    lat_cap_d = lat_cap_q;
    sin_d     = sin_q;
    lat_out_d = lat_out_q;
`ifdef GS_TEST_PATTERN_EN
    tmode_d   = tmode_q;
    pat_d     = pat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        phase_d = PH_ZERO;
        if (enable) state_d = ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_RUN: begin
        // Only leave RUN at the end of a full period so SCLK never emits a partial pulse.
        if (phase_q == PH_LAST) begin
          phase_d = PH_ZERO;
          if (enable) state_d = ST_RUN;
          else        state_d = ST_IDLE;
        end else begin
          phase_d = phase_q + PH_ONE;
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = PH_ZERO;
      end
    endcase
    sclk_d = (state_d == ST_RUN) && (phase_d < PH_HALF);
    if (ph1_s) begin
      valid_d   = read_ok_s && ({1'b0, bit_sel} < 5'(COLOR_DEPTH));
      bitsel_d  = bit_sel;
      lat_cap_d = LAT;
`ifdef GS_TEST_PATTERN_EN
      tmode_d   = test_mode;
      pat_d     = pat_s;
`endif
    end else begin
      valid_d   = valid_q;
      lat_cap_d = lat_cap_q;
    end
    if (ph2_s) begin
      sin_d     = valid_q ? sin_load_s : {NB_CHAINS{1'b0}};
`ifdef GS_TEST_PATTERN_EN
      if (tmode_q) sin_d = pat_q;
      else         sin_d = valid_q ? sin_load_s : {NB_CHAINS{1'b0}};
`endif
      lat_out_d = lat_cap_q;
    end else begin
      sin_d     = sin_q;
      lat_out_d = lat_out_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_ZERO;
      sclk_q    <= 1'b0;
      valid_q   <= 1'b0;
      bitsel_q  <= 4'd0;
      lat_cap_q <= 1'b0;
      sin_q     <= {NB_CHAINS{1'b0}};
      lat_out_q <= 1'b0;
`ifdef GS_TEST_PATTERN_EN
      tmode_q   <= 1'b0;
      pat_q     <= {NB_CHAINS{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      sclk_q    <= sclk_d;
      valid_q   <= valid_d;
      bitsel_q  <= bitsel_d;
      lat_cap_q <= lat_cap_d;
      sin_q     <= sin_d;
      lat_out_q <= lat_out_d;
`ifdef GS_TEST_PATTERN_EN
      tmode_q   <= tmode_d;
      pat_q     <= pat_d;
`endif
    end
  end

endmodule

// File: tb/tb_gs_sin_serializer.sv
// Bench for gs_sin_serializer: acts as GS sequencer and frame RAM, checks SCLK/SIN/LAT_out/rd_* per phase.
module tb_gs_sin_serializer;

  logic        clk = 1'b0;
  logic        rst_n, enable, LAT;
  logic [6:0]  angle;
  logic [3:0]  led, bit_sel, row_en;
  logic [1:0]  color;
  logic        SCLK, LAT_out, rd_en;
  logic [7:0]  SIN;
  logic [14:0] rd_addr;
  logic [79:0] rd_data, ram_word;
`ifdef GS_TEST_PATTERN_EN
  logic        test_mode;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] prev_sin;
  logic       prev_lat;

  always #5 clk = ~clk;

  gs_sin_serializer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .angle(angle), .led(led),
    .color(color), .bit_sel(bit_sel), .row_en(row_en), .LAT(LAT),
`ifdef GS_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .SCLK(SCLK), .SIN(SIN), .LAT_out(LAT_out), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Frame RAM: returns the staged word one cycle after a read, junk otherwise
  always @(posedge clk) begin
    if (rd_en) rd_data <= ram_word;
    else       rd_data <= 80'({$urandom, $urandom, $urandom});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: address as plain arithmetic, SIN as bit bit_sel of each chain's word
  function automatic void model(input logic [6:0] a, input logic [3:0] l, input logic [1:0] col,
                                input logic [3:0] bs, input logic [3:0] re, input logic [79:0] data,
                                output logic rden, output logic [14:0] addr, output logic [7:0] sin);
    int r = -1;
    for (int i = 0; i < 4; i++) if (re == 4'(1 << i)) r = i;
    rden = (r >= 0) && (col != 2'd3);
    addr = 15'(((int'(a) * 4 + (r < 0 ? 0 : r)) * 16 + int'(l)) * 4 + int'(col));
    sin  = 8'd0;
    if (rden && bs < 4'd10)
      for (int c = 0; c < 8; c++) sin[c] = data[c*10 + int'(bs)];
  endfunction

  task automatic scramble();
    angle   = 7'($urandom);
    led     = 4'($urandom);
    color   = 2'($urandom);
    bit_sel = 4'($urandom);
    row_en  = 4'($urandom);
    LAT     = 1'($urandom);
  endtask

  // One SCLK period, entered #1 after the edge that starts phase 0
  task automatic run_period(input logic [6:0] a, input logic [3:0] l, input logic [1:0] col,
                            input logic [3:0] bs, input logic [3:0] re, input logic lat,
                            input logic [79:0] data, input logic exp_rden,
                            input logic [14:0] exp_addr, input logic [7:0] exp_sin);
    @(negedge clk);
    chk("sclk_ph0", 32'(SCLK), 32'd1);
    chk("rden_ph0", 32'(rd_en), 32'd0);
    chk("sin_hold_ph0", 32'(SIN), 32'(prev_sin));
    @(posedge clk); #1;
    angle = a; led = l; color = col; bit_sel = bs; row_en = re; LAT = lat; ram_word = data;
    @(negedge clk);
    chk("sclk_ph1", 32'(SCLK), 32'd1);
    chk("rden_ph1", 32'(rd_en), 32'(exp_rden));
    if (exp_rden) chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
    chk("sin_hold_ph1", 32'(SIN), 32'(prev_sin));
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    chk("sclk_ph2", 32'(SCLK), 32'd0);
    chk("rden_ph2", 32'(rd_en), 32'd0);
    chk("sin_hold_ph2", 32'(SIN), 32'(prev_sin));
    chk("lat_hold_ph2", 32'(LAT_out), 32'(prev_lat));
    @(posedge clk); #1;
    @(negedge clk);
    chk("sclk_ph3", 32'(SCLK), 32'd0);
    chk("sin_ph3", 32'(SIN), 32'(exp_sin));
    chk("lat_out_ph3", 32'(LAT_out), 32'(lat));
    @(posedge clk); #1;
    prev_sin = exp_sin;
    prev_lat = lat;
  endtask

  typedef struct {
    logic [6:0]  a;
    logic [3:0]  l;
    logic [1:0]  col;
    logic [3:0]  bs;
    logic [3:0]  re;
    logic        lat;
    logic [9:0]  we;
    logic [9:0]  wo;
    logic        rden;
    logic [14:0] addr;
    logic [7:0]  sin;
  } vec_t;

  vec_t        tbl[7];
  logic [79:0] data;
  logic        m_rden;
  logic [14:0] m_addr;
  logic [7:0]  m_sin;

  initial begin
    tbl[0] = '{7'd5,   4'd3,  2'd1, 4'd2,  4'b0001, 1'b0, 10'h004, 10'h000, 1'b1, {7'd5,   2'd0, 4'd3,  2'd1}, 8'h55};
    tbl[1] = '{7'd0,   4'd0,  2'd0, 4'd0,  4'b0000, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 15'd0,                       8'h00};
    tbl[2] = '{7'd127, 4'd15, 2'd2, 4'd9,  4'b0100, 1'b1, 10'h200, 10'h000, 1'b1, {7'd127, 2'd2, 4'd15, 2'd2}, 8'h55};
    tbl[3] = '{7'd64,  4'd8,  2'd0, 4'd5,  4'b0010, 1'b0, 10'h000, 10'h020, 1'b1, {7'd64,  2'd1, 4'd8,  2'd0}, 8'hAA};
    tbl[4] = '{7'd10,  4'd1,  2'd3, 4'd0,  4'b0001, 1'b1, 10'h3FF, 10'h3FF, 1'b0, 15'd0,                       8'h00};
    tbl[5] = '{7'd33,  4'd7,  2'd1, 4'd10, 4'b1000, 1'b0, 10'h3FF, 10'h3FF, 1'b1, {7'd33,  2'd3, 4'd7,  2'd1}, 8'h00};
    tbl[6] = '{7'd1,   4'd2,  2'd0, 4'd0,  4'b1000, 1'b0, 10'h3FF, 10'h3FF, 1'b1, {7'd1,   2'd3, 4'd2,  2'd0}, 8'hFF};

    rst_n = 1'b0; enable = 1'b0; angle = 7'd0; led = 4'd0; color = 2'd0;
    bit_sel = 4'd0; row_en = 4'd0; LAT = 1'b0; ram_word = 80'd0;
`ifdef GS_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_sin", 32'(SIN), 32'd0);
    chk("rst_lat_out", 32'(LAT_out), 32'd0);
    chk("rst_rden", 32'(rd_en), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_sclk", 32'(SCLK), 32'd0);
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    chk("first_rise_delay", 32'(SCLK), 32'd0);
    chk("sin_before_load", 32'(SIN), 32'd0);
    @(posedge clk); #1;
    prev_sin = 8'd0;
    prev_lat = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < 8; c++) data[c*10 +: 10] = c[0] ? tbl[i].wo : tbl[i].we;
      run_period(tbl[i].a, tbl[i].l, tbl[i].col, tbl[i].bs, tbl[i].re, tbl[i].lat,
                 data, tbl[i].rden, tbl[i].addr, tbl[i].sin);
    end

    for (int i = 0; i < 40; i++) begin
      logic [6:0] a;
      logic [3:0] l, bs, re;
      logic [1:0] col;
      int r;
      a   = 7'($urandom);
      l   = 4'($urandom);
      col = 2'($urandom);
      bs  = 4'($urandom_range(0, 11));
      r   = int'($urandom_range(0, 4));
      re  = (r == 4) ? 4'd0 : 4'(1 << r);
      data = 80'({$urandom, $urandom, $urandom});
      model(a, l, col, bs, re, data, m_rden, m_addr, m_sin);
      run_period(a, l, col, bs, re, 1'($urandom), data, m_rden, m_addr, m_sin);
    end

`ifdef GS_TEST_PATTERN_EN
    test_mode = 1'b1;
    run_period(7'd9, 4'd1, 2'd1, 4'd0, 4'b0010, 1'b0, 80'({$urandom, $urandom, $urandom}),
               1'b0, 15'd0, 8'h55);
    test_mode = 1'b0;
`endif

    // Stop: enable dropped during phase 0, period must still complete
    row_en = 4'b0001; color = 2'd0; bit_sel = 4'd0; LAT = 1'b1; ram_word = {80{1'b1}};
    enable = 1'b0;
    @(negedge clk);
    chk("stop_sclk_ph0", 32'(SCLK), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stop_sclk_ph1", 32'(SCLK), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stop_sclk_ph2", 32'(SCLK), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stop_sclk_ph3", 32'(SCLK), 32'd0);
    chk("stop_sin", 32'(SIN), 32'hFF);
    chk("stop_lat_out", 32'(LAT_out), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stopped_sclk", 32'(SCLK), 32'd0);
      chk("stopped_rden", 32'(rd_en), 32'd0);
    end

    // Restart, then reset in phase 0
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    chk("restart_delay", 32'(SCLK), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("restart_sclk", 32'(SCLK), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_sclk", 32'(SCLK), 32'd0);
    chk("midrst_sin", 32'(SIN), 32'd0);
    chk("midrst_lat_out", 32'(LAT_out), 32'd0);
    chk("midrst_rden", 32'(rd_en), 32'd0);
    chk("midrst_addr", 32'(rd_addr), 32'd0);
    rst_n = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gs_sin_serializer.md
Name: gs_sin_serializer

Overview:
- Transmit side of the grayscale shift interface. Generates the LED-driver SCLK from clk, which also feeds the GS sequencer.
- Takes the sequencer's angle/led/color/bit_sel/row_en/LAT indexes and fetches pixel words from frame RAM.
- Drives one SIN bit per driver chain, plus a LAT output aligned to those SIN bits.
- Sits between the frame RAM and the LED-driver pins.

Parameters:
- NB_ANGLES, 128, angles per revolution; ANGLE_WIDTH = $clog2(NB_ANGLES).
- NB_LEDS_PER_GROUP, 16, LEDs per multiplex group, power of 2; LED_WIDTH = $clog2.
- NB_CHAINS, 8, parallel driver chains, one SIN each.
- COLOR_DEPTH, 10, bits per color sample; bit_sel range 0..COLOR_DEPTH-1.
- SCLK_DIV, 4, clk cycles per SCLK period; even, >= 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- enable  in  1  run SCLK generation
- angle  in  ANGLE_WIDTH  current angle
- led  in  LED_WIDTH  LED index from sequencer
- color  in  2  R=0, G=1, B=2
- bit_sel  in  4  bit plane
- row_en  in  4  one-hot multiplex row; 0 = idle
- LAT  in  1  latch request from sequencer
- SCLK  out  1  shift clock to drivers and sequencer
- SIN  out  NB_CHAINS  serial data per chain
- LAT_out  out  1  LAT aligned to SIN
- rd_en  out  1  frame RAM read strobe
- rd_addr  out  ANGLE_WIDTH+2+LED_WIDTH+2  {angle, row_idx, led, color}
- rd_data  in  NB_CHAINS*COLOR_DEPTH  RAM word, valid 1 cycle after rd_en; chain c occupies bits [c*COLOR_DEPTH +: COLOR_DEPTH]

Behaviour:
- Reset (rst_n=0 at posedge clk): phase=0, SCLK=0, SIN=0, LAT_out=0, rd_en=0, rd_addr=0, running=0. Applies mid-period; SCLK drops on the next cycle.
- Phase counter 0..SCLK_DIV-1 advances each clk while running.
  - SCLK is registered: 1 for phases 0..SCLK_DIV/2-1, 0 otherwise.
- enable=1 while idle: running=1 and phase=0 on the next clk, so the first SCLK rise comes 1 cycle after enable.
- enable=0 while running: the current period completes; running clears at phase SCLK_DIV-1 and SCLK rests low. No partial pulses.
- The sequencer updates its indexes at the end of phase 0.
- Phase 1: rd_en=1, rd_addr = {angle, row_idx, led, color}; row_idx = one-hot encode of row_en.
- row_en==0 or color==3: no read (rd_en=0); SIN is loaded with 0 at end of phase 2.
- End of phase 2: SIN[c] <= rd_data[c*COLOR_DEPTH + bit_sel], LAT_out <= LAT sampled in phase 1.
  - SIN/LAT_out are stable from phase 3 through the next phase-0 rising edge and change only while SCLK=0.
- bit_sel >= COLOR_DEPTH: SIN forced 0.
- Indexes sampled only in phase 1. Changes in other phases, including new-angle resets, take effect at the next phase 1.
- rd_en is high exactly 1 cycle per SCLK period when a read occurs.

Optional Feature:
- Macro GS_TEST_PATTERN_EN.
- Defined: adds input test_mode (1 bit). When test_mode=1 there is no RAM read (rd_en=0) and SIN[c] = (led[0] ^ c[0]) & (color==row_idx[1:0]), loaded at the same phase-2 point. test_mode=0 behaves as normal.
- Not defined: no test_mode port; RAM path only.

Test Plan:
- Reset then enable=1, SCLK_DIV=4 -> SCLK pattern 1,1,0,0 repeating; first rise 1 cycle after enable; SIN=0 until first load.
- row_en=0001, angle=5, led=3, color=G, bit_sel=2, rd_data chain0=10'h004, chain1=10'h000 -> rd_addr={5,0,3,1}; SIN[0]=1, SIN[1]=0 from phase 3.
- row_en=0000 -> rd_en never asserted; SIN=0 every period.
- LAT=1 sampled in phase 1 -> LAT_out=1 from phase 3 of the same period, low the next period when LAT=0.
- enable dropped at phase 1 -> SCLK completes the low half, then stays 0; rst_n=0 at phase 0 -> SCLK=0 the next cycle, all outputs 0.
- With GS_TEST_PATTERN_EN, test_mode=1, led=1, row_en=0010, color=G -> rd_en=0; SIN[0]=1, SIN[1]=0.
